// File: rtl/rom_byte_assembler.sv
// Parses a length-prefixed byte frame into big-endian 16-bit words and hands each word to
// the ROM stream loader with a load / load_recevied / ack handshake.
module rom_byte_assembler #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid_i,
  input  logic [7:0]             in_data_i,
  output logic                   in_ready_o,
  output logic                   load_o,
  output logic [DATA_WIDTH-1:0]  output_data_o,
  input  logic                   load_recevied_i,
  input  logic                   ack_i,
  output logic [COUNT_WIDTH-1:0] words_written_o,
  output logic [COUNT_WIDTH-1:0] frame_len_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    StHdrHi,
    StHdrLo,
    StWordHi,
    StWordLo,
    StLoad,
    StWaitAck,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic                   load_q, load_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [COUNT_WIDTH-1:0] frame_len_q, frame_len_d;
  logic [COUNT_WIDTH-1:0] words_q, words_d;
  logic                   accept;

  always_comb begin
    in_ready_o = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state_q)
      StHdrHi:  begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      StHdrLo,
      StWordHi,
      StWordLo: in_ready_o = 1'b1;
      StDone:   begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        done_o     = 1'b1;
      end
      default:  in_ready_o = 1'b0;
    endcase
  end

  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    data_d      = data_q;
    frame_len_d = frame_len_q;
    words_d     = words_q;
    case (state_q)
      StHdrHi: begin
        if (accept) begin
          frame_len_d[15:8] = in_data_i;
          words_d           = '0;
          state_d           = StHdrLo;
        end
      end
      StHdrLo: begin
        if (accept) begin
          frame_len_d[7:0] = in_data_i;
          state_d          = (frame_len_d == '0) ? StDone : StWordHi;
        end
      end
      StWordHi: begin
        if (accept) begin
          data_d[15:8] = in_data_i;
          state_d      = StWordLo;
        end
      end
      StWordLo: begin
        if (accept) begin
          data_d[7:0] = in_data_i;
          load_d      = 1'b1;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        if (load_recevied_i) begin
          load_d  = 1'b0;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (ack_i) begin
          words_d = words_q + COUNT_WIDTH'(1);
          state_d = (words_d == frame_len_q) ? StDone : StWordHi;
        end
      end
      StDone: begin
        // First header byte of a back-to-back frame.
        if (accept) begin
          frame_len_d[15:8] = in_data_i;
          words_d           = '0;
          state_d           = StHdrLo;
        end
      end
      default: state_d = StHdrHi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHdrHi;
      load_q      <= 1'b0;
      data_q      <= '0;
      frame_len_q <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      data_q      <= data_d;
      frame_len_q <= frame_len_d;
      words_q     <= words_d;
    end
  end

  assign load_o          = load_q;
  assign output_data_o   = data_q;
  assign frame_len_o     = frame_len_q;
  assign words_written_o = words_q;

endmodule

// File: tb/tb_rom_byte_assembler.sv
// Bench for rom_byte_assembler: table of frames, hand-written corner sequences and random
// frames against a queue-based word model, with a behavioural loader driving the handshake.
module tb_rom_byte_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_ready_o;
  logic        load_o;
  logic [15:0] output_data_o;
  logic        load_recevied_i;
  logic        ack_i;
  logic [15:0] words_written_o;
  logic [15:0] frame_len_o;
  logic        busy_o;
  logic        done_o;

  rom_byte_assembler #(
    .DATA_WIDTH (16),
    .COUNT_WIDTH(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .in_ready_o     (in_ready_o),
    .load_o         (load_o),
    .output_data_o  (output_data_o),
    .load_recevied_i(load_recevied_i),
    .ack_i          (ack_i),
    .words_written_o(words_written_o),
    .frame_len_o    (frame_len_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Loader model: acts on the falling edge so its pulses are stable at the rising edge.
  int          lr_delay  = 0;
  int          ack_delay = 0;
  bit          stray_en  = 1'b0;
  int          phase     = 0;
  int          lcnt;
  int          acnt;
  logic [15:0] cur_word;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  initial begin
    load_recevied_i = 1'b0;
    ack_i           = 1'b0;
    forever begin
      @(negedge clk);
      load_recevied_i = 1'b0;
      ack_i           = 1'b0;
      if (reset) begin
        phase = 0;
      end else begin
        if (phase == 0) begin
          if (load_o) begin
            cur_word = output_data_o;
            got_q.push_back(cur_word);
            lcnt  = lr_delay;
            phase = 1;
          end else if (stray_en && $urandom_range(3, 0) == 0) begin
            // Pulses outside LOAD / WAIT_ACK must be ignored.
            ack_i           = 1'b1;
            load_recevied_i = 1'b1;
          end
        end
        if (phase == 1) begin
          chk("load_held", load_o, 1);
          chk("in_ready_in_load", in_ready_o, 0);
          chk("data_stable_load", output_data_o, cur_word);
          if (lcnt == 0) begin
            load_recevied_i = 1'b1;
            acnt            = ack_delay;
            phase           = 2;
          end else begin
            lcnt--;
          end
        end else if (phase == 2) begin
          chk("load_fell", load_o, 0);
          chk("in_ready_in_wait", in_ready_o, 0);
          chk("data_stable_wait", output_data_o, cur_word);
          if (acnt == 0) begin
            ack_i = 1'b1;
            phase = 0;
          end else begin
            acnt--;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid_i = 1'b1;
    in_data_i  = b;
    while (!in_ready_o && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready_o) chk("send_timeout", in_ready_o, 1);
    else tick();
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_data_i = 8'($urandom);
      tick();
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done_o && t < 5000) begin
      tick();
      t++;
    end
    chk("done_timeout", done_o, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_load", load_o, 0);
    chk("rst_data", output_data_o, 0);
    chk("rst_frame_len", frame_len_o, 0);
    chk("rst_words", words_written_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
  endtask

  // Sends header n plus the words in exp_q, then compares what the loader saw.
  task automatic do_frame(input logic [15:0] n, input int gapmax);
    logic [7:0] tx[$];
    tx.push_back(n[15:8]);
    tx.push_back(n[7:0]);
    foreach (exp_q[i]) begin
      tx.push_back(exp_q[i][15:8]);
      tx.push_back(exp_q[i][7:0]);
    end
    got_q.delete();
    for (int i = 0; i < tx.size(); i++) begin
      if (gapmax > 0) idle($urandom_range(gapmax, 0));
      send_byte(tx[i]);
      if (i == 0) begin
        chk("done_fall", done_o, 0);
        chk("words_restart", words_written_o, 0);
        chk("len_hi", frame_len_o[15:8], n[15:8]);
      end
      if (i == 1 && n == 16'd0) chk("empty_done", done_o, 1);
    end
    wait_done();
    chk("words_written", words_written_o, n);
    chk("frame_len", frame_len_o, n);
    chk("busy_end", busy_o, 0);
    chk("load_end", load_o, 0);
    chk("ready_end", in_ready_o, 1);
    chk("word_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) chk("word_value", got_q[i], exp_q[i]);
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;
    int          lr;
    int          ak;
    logic [15:0] exp_last;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{2, 64'h1234_ABCD_0000_0000, 0, 6, 16'hABCD};
    tbl[1] = '{0, 64'h0000_0000_0000_0000, 0, 0, 16'hABCD};
    tbl[2] = '{1, 64'h1234_0000_0000_0000, 10, 2, 16'h1234};
    tbl[3] = '{3, 64'h0102_0304_0506_0000, 1, 0, 16'h0506};

    reset      = 1'b1;
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;
    tick();
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();

    // Table frames, back-to-back starting from DONE after the first.
    for (int k = 0; k < 4; k++) begin
      exp_q.delete();
      for (int i = 0; i < tbl[k].n; i++) exp_q.push_back(tbl[k].bytes[63-16*i -: 16]);
      lr_delay  = tbl[k].lr;
      ack_delay = tbl[k].ak;
      do_frame(16'(tbl[k].n), 0);
      chk("tbl_last_word", output_data_o, tbl[k].exp_last);
    end

    // Byte held valid through LOAD/WAIT_ACK becomes the next high byte.
    lr_delay  = 0;
    ack_delay = 6;
    got_q.delete();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h55);
    send_byte(8'h66);
    wait_done();
    chk("held_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("held_w0", got_q[0], 16'h1234);
      chk("held_w1", got_q[1], 16'h5566);
    end
    chk("held_words", words_written_o, 2);

    // Reset while waiting for the first ack of a 3-word frame.
    ack_delay = 20;
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int t = 0; t < 20 && phase != 2; t++) tick();
    chk("reach_wait_ack", phase == 2, 1);
    chk("busy_mid", busy_o, 1);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset     = 1'b0;
    ack_delay = 3;
    exp_q.delete();
    exp_q.push_back(16'hBEEF);
    do_frame(16'h0001, 0);
    chk("after_reset_word", output_data_o, 16'hBEEF);

    // Length with a non-zero high byte.
    lr_delay  = 0;
    ack_delay = 0;
    exp_q.delete();
    for (int i = 0; i < 258; i++) exp_q.push_back(16'($urandom));
    do_frame(16'h0102, 0);

    // Random frames, idle gaps, random loader latency and stray pulses.
    stray_en = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int n;
      n         = $urandom_range(6, 0);
      lr_delay  = $urandom_range(4, 0);
      ack_delay = $urandom_range(5, 0);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(16'($urandom));
      do_frame(16'(n), 3);
    end
    stray_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_byte_assembler.md
# rom_byte_assembler

Upstream feeder for `rom_stream_loader`. It consumes a byte stream from the serial receiver using a valid/ready handshake and parses a length-prefixed frame. It assembles big-endian 16-bit instruction words and presents each word to the loader through its `load`/`load_recevied`/`ack` handshake. It tracks how many words have been committed to ROM and flags completion of the frame.

## Interface
- `DATA_WIDTH`, default 16: word width. Fixed at 16 (two bytes per word); other values are unsupported.
- `COUNT_WIDTH`, default 16: width of the frame length field and of the word counter.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  byte available from the serial receiver
- `in_data`  in  8  byte value
- `in_ready`  out  1  byte accepted this cycle when `in_valid && in_ready`
- `load`  out  1  word request to the loader
- `output_data`  out  DATA_WIDTH  word to the loader; feeds the loader's `input_data`
- `load_recevied`  in  1  loader pulse: word sampled
- `ack`  in  1  loader pulse: word written to ROM
- `words_written`  out  COUNT_WIDTH  ROM writes acknowledged in the current frame
- `frame_len`  out  COUNT_WIDTH  N from the current header
- `busy`  out  1  frame in progress (state is not HDR_HI and not DONE)
- `done`  out  1  frame complete; sticky

## Operation
Frame format: N_hi, N_lo, then N words, each sent MSB byte first.

States and transitions:
- HDR_HI: `in_ready`=1. On accept: `frame_len[15:8]`<=byte, clear `words_written`, go to HDR_LO.
- HDR_LO: `in_ready`=1. On accept: `frame_len[7:0]`<=byte. If the full N==0, go to DONE with `done`<=1. Otherwise go to WORD_HI.
- WORD_HI: `in_ready`=1. On accept: `output_data[15:8]`<=byte, go to WORD_LO.
- WORD_LO: `in_ready`=1. On accept: `output_data[7:0]`<=byte, `load`<=1, go to LOAD.
- LOAD: `in_ready`=0, `load` held at 1, `output_data` held stable. On `load_recevied`: `load`<=0, go to WAIT_ACK.
- WAIT_ACK: `in_ready`=0, `load`=0. On `ack`: `words_written`<=`words_written`+1. If the new value equals `frame_len`, go to DONE with `done`<=1. Otherwise go to WORD_HI.
- DONE: `in_ready`=1, `done`=1. On accept: `frame_len[15:8]`<=byte, `done`<=0, clear `words_written`, go to HDR_LO. This starts a back-to-back frame.

Boundary and error rules:
- `ack` seen in any state other than WAIT_ACK is ignored. `load_recevied` seen outside LOAD is ignored.
- `output_data` changes only on a WORD_HI or WORD_LO accept, so it is stable from `load` rise until `ack`.
- `in_data` is ignored whenever `in_ready`=0, and the byte is not consumed.
- Counter arithmetic is COUNT_WIDTH-bit unsigned. N=65535 is legal. `words_written` never exceeds `frame_len`.
- Reset applies in any state, including LOAD or WAIT_ACK: return to HDR_HI. A word already in flight inside the loader is abandoned, because the loader is reset by the same signal.

Reset values: state HDR_HI, `load`=0, `output_data`=0, `frame_len`=0, `words_written`=0, `done`=0, `busy`=0, `in_ready`=1 (combinational from state).

## Timing
- `in_ready`, `busy` and `done` decode combinationally from state. `load` is registered.
- `load` rises the cycle after the low byte is accepted.
- `load` falls on the edge where `load_recevied`=1 is sampled. The loader therefore sees `load` high for one extra cycle while it is already busy, which it ignores.
- Minimum word period is 2 byte cycles + 1 LOAD cycle + 1 WAIT_ACK cycle + the loader/ROM latency.
- `done` rises on the edge that samples the final `ack`. The first `words_written` increment is visible the cycle after `ack`.
- Throughput: one byte per cycle while `in_ready` is high. Bytes are never dropped; the receiver must hold `in_valid` and `in_data` until accepted.

## Test plan
- Header 0x00,0x02 then bytes 12 34 AB CD, with a loader model that pulses `load_recevied` 1 cycle after `load` and `ack` 6 cycles later. Expect `output_data`=0x1234 then 0xABCD, `words_written`=2, `done`=1, `busy`=0.
- Header 0x00,0x00. Expect DONE the cycle after the second byte, `load` never asserted, `words_written`=0.
- Delay `load_recevied` by 10 cycles. Expect `load` held high and `output_data`=0x1234 stable for the whole delay, and `in_ready`=0 throughout.
- Hold `in_valid`=1 with byte 0x55 during WAIT_ACK. Expect no accept. After `ack`, 0x55 is accepted as the high byte of the next word.
- Assert reset in WAIT_ACK of word 1 of a 3-word frame. Expect all outputs at reset values next cycle. A new frame 0x00,0x01,BE,EF completes with `output_data`=0xBEEF.
- After `done`, send header 0x00,0x01 plus 12 34 immediately. Expect `done` to fall on the first byte, `words_written` to restart at 0, and `done` to rise again after one `ack`.
